// File: rtl/ahb_ram_slave_pkg.sv
// Shared types and constants for the AHB-lite RAM responder.
// The state enum is the FSM encoding; the HRESP constants name the two response codes.
package ahb_slv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RESP,
        ERR1,
        ERR2
    } ahb_slv_state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_ram_slave_if.sv
// AHB-lite bus bundle between the interconnect (master side) and the RAM responder (slave side).
interface ahb_ram_slave_if #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
);

    logic                      hsel;
    logic [AHB_ADDR_WIDTH-1:0] haddr;
    logic                      hwrite;
    logic [AHB_DATA_WIDTH-1:0] hwdata;
    logic                      hready;
    logic                      hresp;
    logic [AHB_DATA_WIDTH-1:0] hrdata;

    modport master (
        output hsel,
        output haddr,
        output hwrite,
        output hwdata,
        input  hready,
        input  hresp,
        input  hrdata
    );

    modport slave (
        input  hsel,
        input  haddr,
        input  hwrite,
        input  hwdata,
        output hready,
        output hresp,
        output hrdata
    );

endinterface

// File: rtl/ahb_ram_slave_sram.sv
// Single-port synchronous SRAM model with a registered read port.
// Storage and read register are intentionally left unreset.
module ahb_sram_array #(
    parameter int  DATA_WIDTH  = 32,
    parameter int  DEPTH_WORDS = 1024,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-lite responder for the RAM region: one single-word transfer at a time, fixed wait
// states, and the two-cycle ERROR response for misaligned or out-of-range addresses.
module ahb_ram_slave
    import ahb_slv_pkg::*;
#(
    parameter int                        AHB_ADDR_WIDTH = 32,
    parameter int                        AHB_DATA_WIDTH = 32,
    parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR      = 'h0000_1000,
    parameter int                        DEPTH_WORDS    = 1024,
    parameter int                        WAIT_CYCLES    = 1
) (
    input  logic            clk,
    input  logic            rstn,
    ahb_ram_slave_if.slave  bus
);

    localparam int                        IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [AHB_ADDR_WIDTH-1:0] SPAN_BYTES = AHB_ADDR_WIDTH'(DEPTH_WORDS * 4);
    localparam logic [3:0]                WAIT_INIT  = 4'(WAIT_CYCLES);

    ahb_slv_state_t state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             write_q, write_d;

    logic [AHB_ADDR_WIDTH-1:0] offset;
    logic                      addrErr;
    logic [IDX_W-1:0]          reqIdx;

    logic                      memWe;
    logic                      memRe;
    logic [IDX_W-1:0]          memIdx;
    logic [AHB_DATA_WIDTH-1:0] memRdata;

    // Unsigned wrap makes addresses below BASE_ADDR look huge, so one compare covers both ends.
    assign offset  = bus.haddr - BASE_ADDR;
    assign addrErr = (bus.haddr[1:0] != 2'b00) || (offset >= SPAN_BYTES);
    assign reqIdx  = offset[IDX_W+1:2];

    ahb_sram_array #(
        .DATA_WIDTH  (AHB_DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk   (clk),
        .we    (memWe),
        .re    (memRe),
        .idx   (memIdx),
        .wdata (bus.hwdata),
        .rdata (memRdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
        end
    end

    // The array read is launched on the edge entering RESP so its registered output lines up with RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        memWe   = 1'b0;
        memRe   = 1'b0;
        memIdx  = idx_q;

        case (state_q)
            IDLE: begin
                if (bus.hsel) begin
                    idx_d   = reqIdx;
                    write_d = bus.hwrite;
                    if (addrErr) begin
                        state_d = ERR1;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        memIdx  = reqIdx;
                        memRe   = !bus.hwrite;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    memRe   = !write_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                memWe   = write_q;
            end
            ERR1:    state_d = ERR2;
            ERR2:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.hready = (state_q != WAIT) && (state_q != ERR1);
        bus.hresp  = ((state_q == ERR1) || (state_q == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        bus.hrdata = ((state_q == RESP) && !write_q) ? memRdata : '0;
    end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Self-checking bench: three responders (0, 1 and 3 wait states) share one driver, checked
// against a directed vector table, hand sequences and randomized transfers vs. a word-map model.
module tb_ahb_ram_slave;

   logic        clk;
   logic [2:0]  rstn;
   logic        hsel;
   logic [31:0] haddr;
   logic        hwrite;
   logic [31:0] hwdata;
   int          dutSel;

   logic        curReady;
   logic        curResp;
   logic [31:0] curRdata;

   int total = 0;
   int bad   = 0;

   logic        gotErr;
   logic        gotFirstResp;
   logic [31:0] gotData;
   int          gotLat;

   logic [31:0] model [int];

   ahb_ram_slave_if ifW0 ();
   ahb_ram_slave_if ifW1 ();
   ahb_ram_slave_if ifW3 ();

   assign ifW0.hsel = hsel && (dutSel == 0);
   assign ifW1.hsel = hsel && (dutSel == 1);
   assign ifW3.hsel = hsel && (dutSel == 2);
   assign ifW0.haddr = haddr;
   assign ifW1.haddr = haddr;
   assign ifW3.haddr = haddr;
   assign ifW0.hwrite = hwrite;
   assign ifW1.hwrite = hwrite;
   assign ifW3.hwrite = hwrite;
   assign ifW0.hwdata = hwdata;
   assign ifW1.hwdata = hwdata;
   assign ifW3.hwdata = hwdata;

   ahb_ram_slave #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rstn(rstn[0]), .bus(ifW0));
   ahb_ram_slave #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rstn(rstn[1]), .bus(ifW1));
   ahb_ram_slave #(.WAIT_CYCLES(3)) dut2 (.clk(clk), .rstn(rstn[2]), .bus(ifW3));

   // Route the selected responder's outputs to one set of observation signals.
   always_comb begin
      curReady = ifW0.hready;
      curResp  = ifW0.hresp;
      curRdata = ifW0.hrdata;
      if (dutSel == 1) begin
         curReady = ifW1.hready;
         curResp  = ifW1.hresp;
         curRdata = ifW1.hrdata;
      end else if (dutSel == 2) begin
         curReady = ifW3.hready;
         curResp  = ifW3.hresp;
         curRdata = ifW3.hrdata;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference rules: word-aligned and inside [0x1000, 0x2000) is OKAY, anything else ERROR.
   function automatic logic addrIsErr(input logic [31:0] a);
      return ((a % 4) != 0) || (a < 32'h1000) || (a >= 32'h2000);
   endfunction

   function automatic int waitOf(input int d);
      return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
   endfunction

   function automatic int keyOf(input int d, input logic [31:0] a);
      return d * 4096 + int'((a - 32'h1000) / 4);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One complete transfer; hsel drops right after the start edge and outputs are sampled on negedges.
   task automatic applyStimulus(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd);
      logic done;
      @(negedge clk);
      dutSel = d;
      hsel   = 1'b1;
      haddr  = a;
      hwrite = w;
      hwdata = wd;
      @(negedge clk);
      hsel         = 1'b0;
      done         = 1'b0;
      gotLat       = -1;
      gotErr       = 1'b0;
      gotData      = '0;
      gotFirstResp = curResp;
      for (int n = 1; n <= 40 && !done; n++) begin
         if (n > 1) @(negedge clk);
         if (curReady) begin
            done    = 1'b1;
            gotLat  = n;
            gotErr  = curResp;
            gotData = curRdata;
         end
      end
   endtask

   task automatic checkOutput(input string tag, input logic w, input logic expErr,
                              input logic [31:0] expData, input int expLat);
      check({tag, "_resp"}, {31'd0, gotErr}, {31'd0, expErr});
      check({tag, "_resp1st"}, {31'd0, gotFirstResp}, {31'd0, expErr});
      check({tag, "_lat"}, gotLat, expLat);
      if (!expErr) begin
         check({tag, "_data"}, gotData, w ? 32'h0 : expData);
      end
   endtask

   // Transfer whose expectation comes from the model; the model is updated by completed writes.
   task automatic modelXfer(input string tag, input int d, input logic [31:0] a,
                            input logic w, input logic [31:0] wd);
      logic        e;
      logic [31:0] expD;
      e    = addrIsErr(a);
      expD = '0;
      if (!e && !w) expD = model.exists(keyOf(d, a)) ? model[keyOf(d, a)] : 32'h0;
      applyStimulus(d, a, w, wd);
      checkOutput(tag, w, e, expD, e ? 2 : waitOf(d) + 1);
      if (!e && w) model[keyOf(d, a)] = wd;
   endtask

   task automatic checkIdle(input string tag);
      check({tag, "_hready"}, {31'd0, curReady}, 32'd1);
      check({tag, "_hresp"}, {31'd0, curResp}, 32'd0);
      check({tag, "_hrdata"}, curRdata, 32'd0);
   endtask

   typedef struct {
      int          dut;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic        expErr;
      logic [31:0] expData;
      int          expLat;
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic [31:0] a;
      logic [31:0] v;
      logic [31:0] expD;
      int          r;

      hsel = 1'b0; haddr = '0; hwrite = 1'b0; hwdata = '0; dutSel = 0;
      rstn = 3'b000;

      vecs[0]  = '{1, 32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 2};
      vecs[1]  = '{1, 32'h0000_1004, 1'b0, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 2};
      vecs[2]  = '{0, 32'h0000_1FFC, 1'b1, 32'h1234_5678, 1'b0, 32'h0000_0000, 1};
      vecs[3]  = '{0, 32'h0000_1FFC, 1'b0, 32'h0000_0000, 1'b0, 32'h1234_5678, 1};
      vecs[4]  = '{1, 32'h0000_2000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 2};
      vecs[5]  = '{1, 32'h0000_0FFC, 1'b1, 32'h0BAD_0BAD, 1'b1, 32'h0000_0000, 2};
      vecs[6]  = '{1, 32'h0000_1000, 1'b0, 32'h0000_0000, 1'b0, 32'hA000_1000, 2};
      vecs[7]  = '{1, 32'h0000_1FFC, 1'b0, 32'h0000_0000, 1'b0, 32'hA000_1FFC, 2};
      vecs[8]  = '{1, 32'h0000_1006, 1'b1, 32'hAAAA_AAAA, 1'b1, 32'h0000_0000, 2};
      vecs[9]  = '{1, 32'h0000_1004, 1'b0, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 2};
      vecs[10] = '{2, 32'h0000_1010, 1'b0, 32'h0000_0000, 1'b0, 32'h5555_0001, 4};
      vecs[11] = '{0, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 2};
      vecs[12] = '{2, 32'h0000_1001, 1'b1, 32'h7777_7777, 1'b1, 32'h0000_0000, 2};

      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         dutSel = d;
         #1;
         checkIdle($sformatf("reset_dut%0d", d));
      end
      @(negedge clk);
      rstn = 3'b111;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         dutSel = d;
         #1;
         checkIdle($sformatf("postreset_dut%0d", d));
      end

      $display("[TB] preloading words 0x1000..0x101C, 0x1FF8, 0x1FFC on every responder");
      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < 10; k++) begin
            a = (k < 8) ? 32'h1000 + 32'(4 * k) : ((k == 8) ? 32'h1FF8 : 32'h1FFC);
            v = (a == 32'h1008) ? 32'h0 : ((a == 32'h1010) ? 32'h5555_0001 : (32'hA000_0000 | a));
            modelXfer($sformatf("pre_d%0d_%h", d, a), d, a, 1'b1, v);
         end
      end

      $display("[TB] directed vector table");
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].dut, vecs[i].addr, vecs[i].wr, vecs[i].wdata);
         checkOutput($sformatf("vec%0d", i), vecs[i].wr, vecs[i].expErr, vecs[i].expData, vecs[i].expLat);
         if (!addrIsErr(vecs[i].addr) && vecs[i].wr) model[keyOf(vecs[i].dut, vecs[i].addr)] = vecs[i].wdata;
      end

      $display("[TB] reset during WAIT discards the write");
      @(negedge clk);
      dutSel = 2; hsel = 1'b1; haddr = 32'h1008; hwrite = 1'b1; hwdata = 32'hCAFE_F00D;
      @(negedge clk);
      hsel = 1'b0;
      check("rst_wait1", {31'd0, curReady}, 32'd0);
      @(negedge clk);
      check("rst_wait2", {31'd0, curReady}, 32'd0);
      rstn[2] = 1'b0;
      #1;
      checkIdle("rst_async");
      @(negedge clk);
      rstn[2] = 1'b1;
      modelXfer("rst_readback", 2, 32'h1008, 1'b0, 32'h0);
      check("rst_notnew", {31'd0, gotData == 32'hCAFE_F00D}, 32'd0);

      $display("[TB] hsel held high through RESP");
      expD = model[keyOf(1, 32'h1004)];
      @(negedge clk);
      dutSel = 1; hsel = 1'b1; haddr = 32'h1004; hwrite = 1'b0;
      @(negedge clk);
      check("hold_n1_wait", {31'd0, curReady}, 32'd0);
      @(negedge clk);
      check("hold_n2_ready", {31'd0, curReady}, 32'd1);
      check("hold_n2_data", curRdata, expD);
      @(negedge clk);
      checkIdle("hold_n3_idle");
      @(negedge clk);
      check("hold_n4_wait", {31'd0, curReady}, 32'd0);
      hsel = 1'b0;
      @(negedge clk);
      check("hold_n5_ready", {31'd0, curReady}, 32'd1);
      check("hold_n5_data", curRdata, expD);

      $display("[TB] hsel dropped during WAIT still completes");
      modelXfer("drop_read", 2, 32'h1010, 1'b0, 32'h0);
      check("drop_value", gotData, 32'h5555_0001);
      @(negedge clk);
      checkIdle("drop_after");

      $display("[TB] randomized transfers against the model");
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r < 7)       a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
         else if (r == 7) a = 32'h1000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
         else if (r == 8) a = 32'($urandom_range(0, 32'h0FFF));
         else             a = 32'h2000 + 32'($urandom_range(0, 32'hFFFF));
         modelXfer($sformatf("rnd%0d", i), $urandom_range(0, 2), a, 1'($urandom_range(0, 1)), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
